// File: rtl/sub_pkg.sv
// Shared definitions for the nibble-serial subtractor: FSM states and nibble size.
package sub_pkg;

  localparam int unsigned NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/sub4.sv
// 4-bit borrow-lookahead subtractor: d = x - y - bin, with all borrows computed in parallel.
module sub4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] b;

  // g: this bit borrows on its own; p: this bit passes an incoming borrow through
  assign g = ~x & y;
  assign p = ~(x ^ y);

  assign b[0] = bin;
  assign b[1] = g[0] | (p[0] & bin);
  assign b[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
  assign b[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bin);
  assign b[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & bin);

  assign d    = x ^ y ^ b[3:0];
  assign bout = b[4];

endmodule

// File: rtl/sub_seq.sv
// Nibble-serial subtractor diff = x - y - bin with valid/ready handshakes on both sides.
// Define SUB_SEQ_OVF_EN to add the signed-overflow output ovf.
module sub_seq
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SUB_SEQ_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int unsigned N  = WIDTH / NIBBLE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] xs;
  logic [WIDTH-1:0] ys;
  logic             br;
  logic [3:0]       d4;
  logic             b4;
  logic             last;

`ifdef SUB_SEQ_OVF_EN
  logic x_msb;
  logic y_msb;
`endif

  sub4 u_sub4 (
    .x    (xs[3:0]),
    .y    (ys[3:0]),
    .bin  (br),
    .d    (d4),
    .bout (b4)
  );

  assign last = (cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      xs        <= '0;
      ys        <= '0;
      br        <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      out_valid <= 1'b0;
`ifdef SUB_SEQ_OVF_EN
      x_msb     <= 1'b0;
      y_msb     <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            xs  <= x;
            ys  <= y;
            br  <= bin;
            cnt <= '0;
`ifdef SUB_SEQ_OVF_EN
            x_msb <= x[WIDTH-1];
            y_msb <= y[WIDTH-1];
`endif
          end
        end
        RUN: begin
          // Shift through a WIDTH+4 concatenation so WIDTH=4 needs no empty slice
          diff <= WIDTH'({d4, diff} >> NIBBLE);
          xs   <= xs >> NIBBLE;
          ys   <= ys >> NIBBLE;
          br   <= b4;
          cnt  <= cnt + CW'(1);
          if (last) begin
            bout      <= b4;
            out_valid <= 1'b1;
`ifdef SUB_SEQ_OVF_EN
            ovf <= (x_msb ^ y_msb) & (x_msb ^ d4[3]);
`endif
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_seq.sv
// Randomized self-checking bench for sub_seq against an arithmetic reference model.
module tb_sub_seq;

  localparam int unsigned W = 16;
  localparam int unsigned N = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SUB_SEQ_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  sub_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
`ifdef SUB_SEQ_OVF_EN
    .ovf       (ovf),
`endif
    .bout      (bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, borrow = result went negative
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    longint r;
    logic [W-1:0] dd;
    r  = longint'(a) - longint'(b) - longint'(c);
    dd = W'(r & ((longint'(1) << W) - 1));
    return {(r < 0), dd};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    longint r;
    r = longint'($signed(a)) - longint'($signed(b)) - longint'(c);
    return (r > 32767) || (r < -32768);
  endfunction

  task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                     input int hold, input bit early, input bit noise);
    logic [W:0] e;
    int edges;
    bit seen;
    e = ref_sub(a, b, c);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    x = a;
    y = b;
    bin = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (early) out_ready = 1'b1;
    edges = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        x = W'($urandom);
        y = W'($urandom);
        bin = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      edges++;
      if (out_valid) seen = 1;
    end
    in_valid = 1'b0;
    check("out_valid_seen", seen, 1);
    check("latency", edges, N);
    check("diff", diff, e[W-1:0]);
    check("bout", bout, e[W]);
`ifdef SUB_SEQ_OVF_EN
    check("ovf", ovf, ref_ovf(a, b, c));
`endif
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        if (noise) begin
          in_valid = 1'b1;
          x = W'($urandom);
          y = W'($urandom);
        end
        @(posedge clk);
        #1;
        check("hold_valid", out_valid, 1);
        check("hold_ready", in_ready, 0);
        check("hold_diff", diff, e[W-1:0]);
        check("hold_bout", bout, e[W]);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("taken", out_valid, 0);
    check("back_idle", in_ready, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
`ifdef SUB_SEQ_OVF_EN
    check("rst_ovf", ovf, 0);
`endif

    txn(16'h1234, 16'h0234, 1'b0, 0, 1'b0, 1'b0);
    txn(16'h0000, 16'h0001, 1'b0, 1, 1'b0, 1'b0);
    txn(16'h1000, 16'h0000, 1'b1, 0, 1'b1, 1'b0);
    // Backpressure in DONE with new operands offered, then a clean follow-up
    txn(16'h1234, 16'h0234, 1'b0, 3, 1'b0, 1'b1);
    txn(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0, 1'b0);

    // Reset mid-RUN after two nibbles
    @(negedge clk);
    in_valid = 1'b1;
    x = 16'h1234;
    y = 16'h0001;
    bin = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_diff", diff, 0);
    check("abort_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    txn(16'h0005, 16'h0003, 1'b0, 0, 1'b0, 1'b0);

`ifdef SUB_SEQ_OVF_EN
    txn(16'h8000, 16'h0001, 1'b0, 0, 1'b0, 1'b0);
    txn(16'h0000, 16'h7FFF, 1'b1, 0, 1'b0, 1'b0);
`endif

    for (int k = 0; k < 40; k++) begin
      txn(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
